// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU commands, shift types,
// forwarding selects and status-register bit positions.
package arm_pkg;

    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam logic [1:0] FWD_ID     = 2'b00;
    localparam logic [1:0] FWD_MEM    = 2'b01;
    localparam logic [1:0] FWD_WB     = 2'b10;
    localparam logic [1:0] FWD_ID_ALT = 2'b11;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef struct packed {
        logic wb_en;
        logic memr_en;
        logic memw_en;
    } ctrl_t;

    // Word-aligned PC-relative target; wraps modulo 2^32.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [23:0] imm24);
        return pc + {{6{imm24[23]}}, imm24, 2'b00};
    endfunction

endpackage

// File: rtl/inst_execute_if.sv
// ID/EXE inputs and EXE/MEM outputs of the execute stage bundled as one port.
interface inst_execute_if #(parameter int WIDTH = 32);
    logic             wbEnIn;
    logic             memrEnIn;
    logic             memwEnIn;
    logic             sIn;
    logic             bIn;
    logic [3:0]       exeCmdIn;
    logic [WIDTH-1:0] pcIn;
    logic [WIDTH-1:0] rnValIn;
    logic [WIDTH-1:0] rmValIn;
    logic             immIn;
    logic [11:0]      shOprIn;
    logic [23:0]      signedImm24In;
    logic [3:0]       destIn;
    logic [1:0]       fwdSel1;
    logic [1:0]       fwdSel2;
    logic [WIDTH-1:0] wbFwdVal;
    logic             branchTaken;
    logic [WIDTH-1:0] branchAddr;
    logic [3:0]       srOut;
    logic             wbEnOut;
    logic             memrEnOut;
    logic             memwEnOut;
    logic [WIDTH-1:0] aluResOut;
    logic [WIDTH-1:0] stValOut;
    logic [3:0]       destOut;

    modport master (
        output wbEnIn, memrEnIn, memwEnIn, sIn, bIn, exeCmdIn, pcIn, rnValIn,
               rmValIn, immIn, shOprIn, signedImm24In, destIn, fwdSel1, fwdSel2,
               wbFwdVal,
        input  branchTaken, branchAddr, srOut, wbEnOut, memrEnOut, memwEnOut,
               aluResOut, stValOut, destOut
    );

    modport slave (
        input  wbEnIn, memrEnIn, memwEnIn, sIn, bIn, exeCmdIn, pcIn, rnValIn,
               rmValIn, immIn, shOprIn, signedImm24In, destIn, fwdSel1, fwdSel2,
               wbFwdVal,
        output branchTaken, branchAddr, srOut, wbEnOut, memrEnOut, memwEnOut,
               aluResOut, stValOut, destOut
    );
endinterface

// File: rtl/val2_gen.sv
// Second ALU operand: memory offset, rotated 8-bit immediate, or
// immediate-shifted register.
module val2_gen
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] store_val,
    input  logic [11:0]      sh_opr,
    input  logic             imm,
    input  logic             mem_access,
    output logic [WIDTH-1:0] val2
);

    logic [4:0]         amt;
    logic [4:0]         rot;
    logic [WIDTH-1:0]   imm8;
    logic [2*WIDTH-1:0] rot_imm;
    logic [2*WIDTH-1:0] rot_reg;

    always_comb begin
        amt     = sh_opr[11:7];
        rot     = {sh_opr[11:8], 1'b0};
        imm8    = {{(WIDTH-8){1'b0}}, sh_opr[7:0]};
        // Shifting a doubled word right leaves a rotation in the low half.
        rot_imm = {imm8, imm8} >> rot;
        rot_reg = {store_val, store_val} >> amt;
        val2    = store_val;

        if (mem_access) begin
            val2 = {{(WIDTH-12){1'b0}}, sh_opr};
        end else if (imm) begin
            val2 = rot_imm[WIDTH-1:0];
        end else begin
            // Bit 4 (register-specified shift) is not supported; both
            // encodings take the immediate-amount path.
            case (sh_opr[6:4])
                {SH_LSL, 1'b0}, {SH_LSL, 1'b1}: val2 = store_val << amt;
                {SH_LSR, 1'b0}, {SH_LSR, 1'b1}: val2 = store_val >> amt;
                {SH_ASR, 1'b0}, {SH_ASR, 1'b1}: val2 = $signed(store_val) >>> amt;
                default:                        val2 = rot_reg[WIDTH-1:0];
            endcase
        end
    end

endmodule

// File: rtl/inst_execute.sv
// Execute stage: operand forwarding, Val2, ALU with NZCV status register,
// branch target, and the EXE/MEM pipe register.
module inst_execute
    import arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    inst_execute_if.slave ex
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] store_val;
    logic [WIDTH-1:0] val2;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum;
    logic             c_new;
    logic             v_new;
    logic             cmd_ok;
    logic [3:0]       sr_next;

    logic [3:0]       sr;
    ctrl_t            ctrl_p1;
    logic [WIDTH-1:0] alu_res_p1;
    logic [WIDTH-1:0] st_val_p1;
    logic [3:0]       dest_p1;

    // The MEM source is the pre-edge EXE/MEM result, i.e. the previous instruction.
    always_comb begin
        case (ex.fwdSel1)
            FWD_MEM:            op1 = alu_res_p1;
            FWD_WB:             op1 = ex.wbFwdVal;
            FWD_ID, FWD_ID_ALT: op1 = ex.rnValIn;
            default:            op1 = ex.rnValIn;
        endcase
        case (ex.fwdSel2)
            FWD_MEM:            store_val = alu_res_p1;
            FWD_WB:             store_val = ex.wbFwdVal;
            FWD_ID, FWD_ID_ALT: store_val = ex.rmValIn;
            default:            store_val = ex.rmValIn;
        endcase
    end

    val2_gen #(.WIDTH(WIDTH)) u_val2_gen (
        .store_val  (store_val),
        .sh_opr     (ex.shOprIn),
        .imm        (ex.immIn),
        .mem_access (ex.memrEnIn | ex.memwEnIn),
        .val2       (val2)
    );

    // Subtraction is op1 + ~val2 + 1, so carry-out is the ARM "no borrow" C.
    always_comb begin
        alu_res = '0;
        sum     = '0;
        c_new   = sr[SR_C];
        v_new   = sr[SR_V];
        cmd_ok  = 1'b1;
        case (ex.exeCmdIn)
            EXE_MOV: alu_res = val2;
            EXE_MVN: alu_res = ~val2;
            EXE_ADD, EXE_ADC: begin
                sum     = {1'b0, op1} + {1'b0, val2}
                        + {{WIDTH{1'b0}}, (ex.exeCmdIn == EXE_ADC) & sr[SR_C]};
                alu_res = sum[MSB:0];
                c_new   = sum[WIDTH];
                v_new   = (op1[MSB] == val2[MSB]) && (alu_res[MSB] != op1[MSB]);
            end
            EXE_SUB, EXE_SBC: begin
                sum     = {1'b0, op1} + {1'b0, ~val2}
                        + {{WIDTH{1'b0}}, (ex.exeCmdIn == EXE_SUB) | sr[SR_C]};
                alu_res = sum[MSB:0];
                c_new   = sum[WIDTH];
                v_new   = (op1[MSB] != val2[MSB]) && (alu_res[MSB] != op1[MSB]);
            end
            EXE_AND: alu_res = op1 & val2;
            EXE_ORR: alu_res = op1 | val2;
            EXE_EOR: alu_res = op1 ^ val2;
            default: cmd_ok = 1'b0;
        endcase

        sr_next = sr;
        if (cmd_ok) begin
            sr_next[SR_N] = alu_res[MSB];
            sr_next[SR_Z] = (alu_res == '0);
            sr_next[SR_C] = c_new;
            sr_next[SR_V] = v_new;
        end
    end

    // EXE/MEM boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            ctrl_p1    <= '0;
            alu_res_p1 <= '0;
            st_val_p1  <= '0;
            dest_p1    <= '0;
        end else begin
            if (ex.sIn) begin
                sr <= sr_next;
            end
            ctrl_p1.wb_en   <= ex.wbEnIn;
            ctrl_p1.memr_en <= ex.memrEnIn;
            ctrl_p1.memw_en <= ex.memwEnIn;
            alu_res_p1      <= alu_res;
            st_val_p1       <= store_val;
            dest_p1         <= ex.destIn;
        end
    end

    assign ex.branchTaken = ex.bIn;
    assign ex.branchAddr  = branch_target(ex.pcIn, ex.signedImm24In);
    assign ex.srOut       = sr;
    assign ex.wbEnOut     = ctrl_p1.wb_en;
    assign ex.memrEnOut   = ctrl_p1.memr_en;
    assign ex.memwEnOut   = ctrl_p1.memw_en;
    assign ex.aluResOut   = alu_res_p1;
    assign ex.stValOut    = st_val_p1;
    assign ex.destOut     = dest_p1;

endmodule

// File: doc/inst_execute.md
Name: inst_execute

Overview:
- Execute stage of the 5-stage ARM pipeline, directly downstream of the decode stage and its ID/EXE pipe register.
- Takes decoded control, operands, shifter operand and branch offset; forms Val2; runs the ALU; computes the branch target.
- Owns the NZCV status register, which feeds the decode stage's condition check.
- Registers the results into the EXE/MEM pipe register for the memory stage.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wbEnIn, memrEnIn, memwEnIn  in  1 each  control bits from the ID/EXE register.
- sIn  in  1  update flags this cycle.
- bIn  in  1  branch instruction.
- exeCmdIn  in  4  ALU command.
- pcIn  in  32  PC+4 of the instruction.
- rnValIn, rmValIn  in  32 each  register operands.
- immIn  in  1  I bit.
- shOprIn  in  12  shifter operand / offset.
- signedImm24In  in  24  branch offset.
- destIn  in  4  destination register.
- fwdSel1, fwdSel2  in  2 each  forwarding select. 00 = ID value, 01 = aluResOut (own EXE/MEM register), 10 = wbFwdVal, 11 = ID value.
- wbFwdVal  in  32  write-back stage value.
- branchTaken  out  1  combinational; equals bIn. Drives IF PC mux and ID flush.
- branchAddr  out  32  combinational target.
- srOut  out  4  status register {N,Z,C,V}.
- wbEnOut, memrEnOut, memwEnOut  out  1 each  registered control bits.
- aluResOut  out  32  registered ALU result / memory address.
- stValOut  out  32  registered store data (forwarded operand 2).
- destOut  out  4  registered destination.

Behaviour:
- Operand selection: op1 = rnValIn forwarded by fwdSel1; storeVal = rmValIn forwarded by fwdSel2. Forwarding applies before Val2 generation.
- Val2 when memrEnIn or memwEnIn: zero-extended shOprIn[11:0]; the I bit is ignored.
- Val2 when immIn=1: {24'b0, shOprIn[7:0]} rotated right by 2*shOprIn[11:8].
- Val2 otherwise: storeVal shifted by shOprIn[11:7]. Shift type shOprIn[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. Register-specified shift (bit4=1) is not supported; treat as shift-imm. A shift amount of 0 passes the value through unchanged.
- ALU by exeCmdIn:
  - 0001 MOV: Val2. 1001 MVN: ~Val2.
  - 0010 ADD: op1+Val2. 0011 ADC: op1+Val2+C.
  - 0100 SUB: op1-Val2. 0101 SBC: op1-Val2-~C.
  - 0110 AND, 0111 ORR, 1000 EOR.
  - Any other code: result 0, flags unchanged.
- Flags:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = carry-out (subtract: C = no borrow); V = signed overflow, computed on 33-bit sums.
  - Logical ops and MOV/MVN: C and V keep their previous values.
- Status register: on a clock edge with sIn=1 and rst=0, SR <= {N,Z,C,V}; otherwise it holds. ADC/SBC use the current SR.C, i.e. the value before this edge.
- Branch target: branchAddr = pcIn + (sign-extended signedImm24In << 2), computed in 32 bits, wrap-around modulo 2^32. Combinational, so there is zero-cycle latency to IF.
- EXE/MEM register: every clock edge captures wbEnIn, memrEnIn, memwEnIn, ALU result, storeVal and destIn. Latency is 1 cycle. There is no stall input.
- Reset: all registered outputs and SR go to 0 at the next edge with rst=1. Reset mid-operation discards the in-flight instruction; the EXE/MEM register then holds a bubble with all enables 0.
- Simultaneous events: fwdSel=01 in the same cycle the register updates reads the pre-edge aluResOut, which is the intended previous-instruction value.

Decomposition:
- Package arm_pkg: exeCmd localparams (EXE_MOV … EXE_EOR), shift-type constants, fwdSel constants, and the SR bit indices N=3, Z=2, C=1, V=0.
- One natural sub-module: val2_gen (combinational Val2 generator).
- The ALU and the EXE/MEM register stay inline.

Test Plan:
- ADD with flags: op1=0x7FFFFFFF, Val2 imm=1, sIn=1 → aluResOut=0x80000000 next cycle; srOut=1001 (N=1, V=1).
- Subtract with borrow: SUB 5-5, sIn=1 → result 0, srOut=0110. A following SBC 3-1 uses C=1 → result 2.
- Val2 rotate: immIn=1, shOpr=0x4FF → Val2=0xFF000000. Shift-imm ASR 4 of 0x80000000 → 0xF8000000. ROR 8 of 0x12345678 → 0x78123456.
- Branch target: bIn=1, pcIn=0x100, imm24=0xFFFFFE (-2) → branchTaken=1 and branchAddr=0xF8 in the same cycle; wbEnOut=0.
- Forwarding: back-to-back ADD R1 then ADD R2,R1 with fwdSel1=01 → the second op uses the first result. fwdSel2=10 with a STR → stValOut=wbFwdVal.
- Reset mid-stream: rst high during a CMP with sIn=1 → srOut=0 and all enables 0 next cycle; after rst drops, the next instruction executes normally.
